sram_controller: RTL

- Bus slave that converts word transactions on the system bus into asynchronous SRAM read/write cycles on the 32-bit external SRAM chip.
- Sits directly downstream of the bus decoder; it is selected when the address falls in the RAM prefix region, `12'h00?`.
- Holds the master in `stall` until each SRAM cycle's timing requirements are met.

---
 rtl/sram_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Bus slave that turns single-word bus reads/writes into asynchronous SRAM cycles.
// The master is held in stall until the strobe timing for the current cycle has been met.
`timescale 1ns/1ps
module sram_controller #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic [3:0]  mask,
    output logic        stall,
    output logic [31:0] data_rd,
    output logic [31:0] data_rd_2,
    output logic [5:0]  interrupt,
    output logic [19:0] sram_address,
    inout  wire  [31:0] sram_data,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);
    localparam int MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [19:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be_n;
    logic [31:0]        r_data_rd;
    logic               w_drive;
    logic               w_capture;
    logic               w_unused_addr;

    // Only the chip word address is decoded here; the rest is the decoder's business.
    assign w_unused_addr = ^{address[31:22], address[1:0]};

    assign w_capture = (r_state == RD_WAIT) && (r_cnt == '0);

    // NOTE: every register uses <= so all of them sample pre-edge values, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be_n    <= 4'b1111;
            r_data_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == IDLE && write) begin
                r_addr  <= address[21:2];
                r_wdata <= data_wr;
                r_be_n  <= ~mask;
            end else if (r_state == IDLE && read) begin
                r_addr <= address[21:2];
            end
            if (w_capture) begin
                r_data_rd <= sram_data;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_be_n   = 4'b1111;
        w_drive     = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset must release the master even while it keeps its request up.
                stall = (read | write) & ~rst;
                if (write) begin
                    w_state_nxt = WR_SETUP;
                end else if (read) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = CNT_W'(READ_CYCLES - 1);
                end
            end
            RD_WAIT: begin
                stall     = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'b0000;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WR_SETUP: begin
                stall       = 1'b1;
                sram_ce_n   = 1'b0;
                sram_be_n   = r_be_n;
                w_drive     = 1'b1;
                w_state_nxt = WR_PULSE;
                w_cnt_nxt   = CNT_W'(WRITE_CYCLES - 1);
            end
            WR_PULSE: begin
                stall     = 1'b1;
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                sram_be_n = r_be_n;
                w_drive   = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WR_HOLD: begin
                stall       = 1'b1;
                sram_ce_n   = 1'b0;
                sram_be_n   = r_be_n;
                w_drive     = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sram_data    = w_drive ? r_wdata : 'z;
    assign sram_address = r_addr;
    assign data_rd      = r_data_rd;
    assign data_rd_2    = '0;
    assign interrupt    = '0;

endmodule
